// File: rtl/fifo_rd_stream.sv
// Read-domain drain adapter: pops the async FIFO against its empty flag, absorbs the
// one-cycle read latency and presents words as a valid/ready stream via a 2-entry buffer.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    logic [1:0]            occ_q, occ_d, occ_pop;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pop;

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf0_q;
    assign rd_count = cnt_q;
    assign pop      = m_valid & m_ready;

    // Occupancy after this cycle's pop, then after the in-flight word lands.
    // A new pop is only issued if that word would still have a free slot.
    assign occ_pop   = occ_q - {1'b0, pop};
    assign occ_d     = occ_pop + {1'b0, inflight_q};
    assign fifo_r_en = ~rst & en & ~fifo_empty & (occ_d < 2'd2);

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (occ_q == 2'd2) begin
                buf0_d = buf1_q;
            end
        end
        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                buf0_d = fifo_rdata;
            end else begin
                buf1_d = fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_r_en;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain adapter for the asynchronous FIFO. Lives in the read clock domain, issues `r_en` pops against the FIFO's registered `empty` flag, absorbs the FIFO's one-cycle registered read latency, and presents the words to a downstream consumer as a valid/ready stream. Word order is preserved. A 2-entry output buffer sustains one word per cycle when the consumer is always ready.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width and stream data width.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.
- `clk`  in  1: read-domain clock, the same clock as the FIFO `rclk`.
- `rst`  in  1: reset, synchronous and active-high. The top level drives the FIFO `rrst_n` as `~rst`.
- `en`  in  1: drain enable. When low, no new pops are issued; in-flight words are still captured.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rdata`  in  DATA_WIDTH: FIFO `data_out`, valid one cycle after an accepted pop.
- `fifo_r_en`  out  1: pop request to the FIFO.
- `m_valid`  out  1: stream word valid.
- `m_data`  out  DATA_WIDTH: stream word.
- `m_ready`  in  1: consumer accepts the word.
- `rd_count`  out  CNT_WIDTH: number of words handed to the consumer. Wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - 2-entry buffer, registers `buf0` (head) and `buf1`.
  - 2-bit occupancy `occ` (0..2).
  - 1-bit `inflight` flag.
  - `rd_count`.
- `pop = m_valid & m_ready`.
- `fifo_r_en = en & ~fifo_empty & ((occ + inflight - pop) < 2)`.
  - This is combinational from `m_ready` and `fifo_empty`.
  - `fifo_r_en` is never asserted while `fifo_empty` is high.
- `inflight` is set to `fifo_r_en` each cycle, a registered one-cycle delay.
- Capture: when `inflight` is 1, `fifo_rdata` is written into the buffer that cycle.
  - It goes to the tail slot after any same-cycle pop has been applied.
- Occupancy update: `occ_next = occ + inflight - pop`.
  - The issue rule guarantees `occ_next <= 2`.
  - Overflow is impossible by construction. The bench asserts it.
- Pop with `occ == 2`: `buf1` shifts to `buf0`. If a capture happens the same cycle, the new word goes to `buf1`.
- Outputs:
  - `m_valid = (occ != 0)`.
  - `m_data = buf0`, registered.
  - `m_data` holds its value while `m_valid & ~m_ready` (AXI-style stability).
- `rd_count` increments by 1 on every `pop`, with no saturation.
- `en` falling with a read in flight: that word is still captured and delivered. Nothing is dropped.
- Reset values:
  - `occ = 0`, `inflight = 0`, `buf0 = buf1 = 0`, `rd_count = 0`.
  - Hence `m_valid = 0`, `m_data = 0`, and `fifo_r_en = 0` while `rst` is high.
- Reset mid-operation: any in-flight or buffered words are discarded. The FIFO read pointer resets at the same time through `rrst_n`, so no stale pop is accounted for.

## Timing
- Cycle t: `fifo_r_en = 1`, which implies `fifo_empty = 0`.
- t+1: `fifo_rdata` valid and captured at the end of t+1.
- t+2: the word is on `m_data` with `m_valid = 1` at the earliest.
- Latency from `fifo_empty` falling (with an empty buffer and `en = 1`) to `m_valid`: 2 cycles.
- Steady state with `m_ready` held at 1 and a non-empty FIFO: `fifo_r_en` and `m_valid` are high every cycle, giving 1 word per cycle.
- Backpressure:
  - `m_ready = 0` for k cycles: at most 2 words are buffered and `fifo_r_en` drops within 1 cycle.
  - After `m_ready` returns, data resumes in the next cycle.
- `fifo_empty` is pessimistic because of synchronizer delay. The block simply waits; no timeout exists.

## Test plan
- Reset: hold `rst` for 3 cycles with a non-empty FIFO. Require `fifo_r_en = 0`, `m_valid = 0`, `m_data = 0`, `rd_count = 0`. The first `fifo_r_en` occurs in the cycle after `rst` falls, and the first `m_valid` 2 cycles later.
- Streaming: write 0x01..0x10 (16 words), hold `m_ready = 1`. Require `m_data` to be 0x01..0x10 in order on 16 consecutive valid cycles, and `rd_count = 16`.
- Backpressure: pattern `m_ready` 1,0,0,0,1,0,1,1... over 32 words. Require:
  - no loss or duplication, order preserved;
  - `m_data` stable while stalled;
  - `occ` never above 2;
  - `fifo_r_en` never high while `fifo_empty` is high.
- Enable gating:
  - Drop `en` in the same cycle as a `fifo_r_en` pulse. Require that word to still be delivered, with no further pops.
  - Raise `en` after 10 cycles. Require pops to resume in that same cycle.
- Empty boundary: write 1 word into an empty FIFO. Require exactly one `fifo_r_en` pulse and one `m_valid` beat, with `m_valid` low thereafter and `rd_count = 1`.
- Mid-operation reset and wrap:
  - Assert `rst` with 2 words buffered and 1 in flight. Require `m_valid = 0` in the cycle after the reset edge.
  - With `CNT_WIDTH = 4`, stream 17 words. Require `rd_count = 1`.
